// File: rtl/ram_loader_if.sv
// Host byte stream plus RAM write port and loader status, bundled for the loader.
interface ram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  cpu_halt;
  logic                  load_done;
  logic                  load_error;

  // Environment side: drives the stream, observes RAM port and status.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, ram_we, ram_addr, ram_data, cpu_halt, load_done, load_error
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, ram_we, ram_addr, ram_data, cpu_halt, load_done, load_error
  );
endinterface

// File: rtl/ram_loader.sv
// Framed program loader: HEADER, ADDR, COUNT, COUNT data bytes, CHK -> RAM writes.
module ram_loader #(
  parameter int unsigned           ADDR_WIDTH     = 4,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] HEADER_BYTE    = 'hA5,
  parameter int unsigned           TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_loader_if.slave   bus
);

  localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX_COUNT = DATA_WIDTH'(DEPTH);
  localparam int unsigned           TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE, S_CHK
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  halt_q, halt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ready;
  logic                  xfer;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      chk_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      chk_q   <= chk_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update for one accepted byte or one idle cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    chk_d   = chk_q;
    tmo_d   = '0;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    halt_d  = halt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    xfer    = bus.rx_valid && ready;

    // Inter-byte watchdog; only byte-waiting states inside a frame count.
    if (state_q inside {S_ADDR, S_COUNT, S_DATA, S_CHK} && !xfer) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        halt_d  = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (xfer && bus.rx_data == HEADER_BYTE) begin
          state_d = S_ADDR;
          halt_d  = 1'b1;
          err_d   = 1'b0;
          chk_d   = '0;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          if (bus.rx_data[DATA_WIDTH-1:ADDR_WIDTH] != '0) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            halt_d  = 1'b0;
          end else begin
            ptr_d   = bus.rx_data[ADDR_WIDTH-1:0];
            chk_d   = chk_q + bus.rx_data;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if (bus.rx_data == '0 || bus.rx_data > MAX_COUNT) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            halt_d  = 1'b0;
          end else begin
            rem_d   = bus.rx_data[ADDR_WIDTH:0];
            chk_d   = chk_q + bus.rx_data;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          waddr_d = ptr_q;
          wdata_d = bus.rx_data;
          we_d    = 1'b1;
          chk_d   = chk_q + bus.rx_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        we_d    = 1'b0;
        ptr_d   = ptr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == 1) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer) begin
          if (bus.rx_data == chk_q) done_d = 1'b1;
          else                      err_d  = 1'b1;
          halt_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: ready is decoded from state and gated by reset; the rest are registered.
  always_comb begin
    ready          = rst_n && (state_q != S_WRITE);
    bus.rx_ready   = ready;
    bus.ram_we     = we_q;
    bus.ram_addr   = waddr_q;
    bus.ram_data   = wdata_q;
    bus.cpu_halt   = halt_q;
    bus.load_done  = done_q;
    bus.load_error = err_q;
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: frame table plus timeout and mid-frame reset sequences.
module tb_ram_loader;

  logic clk;
  logic rst_n;

  ram_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  ram_loader #(
    .ADDR_WIDTH    (4),
    .DATA_WIDTH    (8),
    .HEADER_BYTE   (8'hA5),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           n;     // bytes in vector
    logic [159:0] v;     // bytes right-aligned, byte 0 most significant
    int           hdr;   // index of the header byte
    int           wr;    // expected RAM writes
    int           done;  // expected load_done pulses
    int           err;   // expected load_error at the end
  } vec_t;

  vec_t       tbl[$];
  int         checks   = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [3:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [7:0] tb_mem[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input vec_t f, input int i);
    return f.v[8*(f.n-1-i) +: 8];
  endfunction

  // Record every RAM write and every completion pulse.
  always @(negedge clk) begin
    if (bus.ram_we) begin
      wr_a.push_back(bus.ram_addr);
      wr_d.push_back(bus.ram_data);
      tb_mem[bus.ram_addr] = bus.ram_data;
      check("ready_low_in_write", 32'(bus.rx_ready), 32'(0));
    end
    if (bus.load_done) begin
      done_cnt++;
      check("done_err_exclusive", 32'(bus.load_error), 32'(0));
    end
  end

  task automatic send_byte(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("accept_%02h", d), 32'(ok), 32'(1));
  endtask

  task automatic add(input int n, input logic [159:0] v, input int hdr,
                     input int wr, input int done, input int err);
    vec_t r;
    r.n = n; r.v = v; r.hdr = hdr; r.wr = wr; r.done = done; r.err = err;
    tbl.push_back(r);
  endtask

  task automatic run_frame(input int k);
    vec_t       f;
    logic [7:0] b;
    logic [3:0] start;
    f = tbl[k];
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    for (int i = 0; i < f.n; i++) begin
      send_byte(byte_of(f, i));
      check($sformatf("f%0d_halt_b%0d", k, i), 32'(bus.cpu_halt),
            32'(i >= f.hdr && i < f.n - 1));
    end
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("f%0d_wr_count", k), 32'(wr_a.size()), 32'(f.wr));
    check($sformatf("f%0d_done_count", k), 32'(done_cnt), 32'(f.done));
    check($sformatf("f%0d_error", k), 32'(bus.load_error), 32'(f.err));
    check($sformatf("f%0d_halt_end", k), 32'(bus.cpu_halt), 32'(0));
    b = byte_of(f, f.hdr + 1);
    start = b[3:0];
    for (int j = 0; j < f.wr && j < wr_a.size(); j++) begin
      check($sformatf("f%0d_wr%0d_addr", k, j), 32'(wr_a[j]), 32'(4'(start + 4'(j))));
      check($sformatf("f%0d_wr%0d_data", k, j), 32'(wr_d[j]), 32'(byte_of(f, f.hdr + 3 + j)));
    end
  endtask

  // A good header after a failed frame clears the sticky error.
  task automatic err_clear_seq();
    done_cnt = 0;
    send_byte(8'hA5);
    check("hdr_clears_error", 32'(bus.load_error), 32'(0));
    check("hdr_sets_halt", 32'(bus.cpu_halt), 32'(1));
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'h5B);
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("clear_seq_done", 32'(done_cnt), 32'(1));
    check("clear_seq_error", 32'(bus.load_error), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},   32'(bus.rx_ready),   32'(0));
    check({tag, "_ram_we"},     32'(bus.ram_we),     32'(0));
    check({tag, "_ram_addr"},   32'(bus.ram_addr),   32'(0));
    check({tag, "_ram_data"},   32'(bus.ram_data),   32'(0));
    check({tag, "_cpu_halt"},   32'(bus.cpu_halt),   32'(0));
    check({tag, "_load_done"},  32'(bus.load_done),  32'(0));
    check({tag, "_load_error"}, 32'(bus.load_error), 32'(0));
  endtask

  initial begin
    logic [159:0] t;
    int           k;

    add(8, 160'({8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h1F, 8'h55, 8'h76}), 2, 2, 1, 0);
    add(7, 160'({8'hA5, 8'h0F, 8'h03, 8'h11, 8'h22, 8'h33, 8'h78}), 0, 3, 1, 0);
    add(5, 160'({8'hA5, 8'h03, 8'h01, 8'hAA, 8'h00}), 0, 1, 0, 1);
    add(2, 160'({8'hA5, 8'h10}), 0, 0, 0, 1);
    add(3, 160'({8'hA5, 8'h00, 8'h00}), 0, 0, 0, 1);
    add(3, 160'({8'hA5, 8'h00, 8'h11}), 0, 0, 0, 1);
    t = 160'({8'hA5, 8'h04, 8'h10});
    for (int i = 0; i < 16; i++) t = {t[151:0], 8'(i)};
    t = {t[151:0], 8'h8C};
    add(20, t, 0, 16, 1, 0);

    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(bus.rx_ready), 32'(1));

    for (int i = 0; i < tbl.size(); i++) begin
      run_frame(i);
      if (i == 2) err_clear_seq();
    end

    // Inter-byte timeout: abort lands 21 edges after the last data byte
    // (one WRITE cycle, then 20 idle cycles in DATA).
    wr_a.delete();
    wr_d.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h01);
    bus.rx_valid = 1'b0;
    k = 41;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.load_error) begin
        k = c;
        break;
      end
    end
    check("timeout_edge", 32'(k), 32'(21));
    check("timeout_halt", 32'(bus.cpu_halt), 32'(0));
    check("timeout_wr_count", 32'(wr_a.size()), 32'(1));

    // Mid-frame reset right after the second data byte.
    wr_a.delete();
    wr_d.delete();
    send_byte(8'hA5);
    check("after_timeout_hdr_halt", 32'(bus.cpu_halt), 32'(1));
    check("after_timeout_hdr_err", 32'(bus.load_error), 32'(0));
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst_n       = 1'b1;
    bus.rx_data = 8'h33;
    repeat (5) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_wr_count", 32'(wr_a.size()), 32'(2));
    check("midrst_mem0", 32'(tb_mem[0]), 32'(8'h11));
    check("midrst_mem1", 32'(tb_mem[1]), 32'(8'h22));
    check("midrst_halt", 32'(bus.cpu_halt), 32'(0));
    check("midrst_error", 32'(bus.load_error), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
